mips_fetch_unit: RTL and testbench

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

---
 rtl/mips_fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/mips_fetch_unit.sv | 110 +++++++++++
 tb/tb_mips_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch buffer holding {pc, instruction} entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding a prefetch buffer,
// with redirect flush and a DISCARD state that drains a request whose data is stale.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [DATA_W-1:0]        instruction,
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        pc_new,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_state_e             state_dbg
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]         held_addr_q, held_addr_d;
    logic                      push, pop;
    logic [CNT_W-1:0]          count_next;
    logic [ADDR_W+DATA_W-1:0]  head_data;

    // Handshakes: a head entry moves on any cycle with inst_valid & inst_ready; a memory
    // request keeps imem_req and imem_addr steady until the imem_ack cycle, which may be
    // the very first request cycle. Redirect suppresses both push and pop.
    assign pop        = inst_valid & inst_ready & ~redirect_valid;
    assign push       = (state_q == ST_REQ) & imem_ack & ~redirect_valid;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign inst_valid = (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            held_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            held_addr_q <= held_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid || (count_next < CNT_W'(DEPTH))) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) state_d = imem_ack ? ST_REQ : ST_DISCARD;
                else if (imem_ack) state_d = (count_next < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
            end
            ST_DISCARD: begin
                if (imem_ack) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // While discarding, imem_addr comes from held_addr so fetch_pc can track redirects.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        held_addr_d = held_addr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if ((state_q == ST_REQ) && !imem_ack) held_addr_d = fetch_pc_q;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_comb begin
        imem_req  = (state_q != ST_IDLE);
        imem_addr = (state_q == ST_DISCARD) ? held_addr_q : fetch_pc_q;
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({fetch_pc_q, imem_rdata}),
        .head_data (head_data),
        .count     (count)
    );

    assign pc          = head_data[ADDR_W+DATA_W-1:DATA_W];
    assign instruction = head_data[DATA_W-1:0];
    assign pc_new      = pc + ADDR_W'(PC_STEP);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: scoreboarded delivery plus state/port checks.
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    logic        clock;
    logic        reset;
    logic        imem_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        imem_req,   imem_req_w;
    logic [31:0] imem_addr,  imem_addr_w;
    logic [31:0] imem_rdata, imem_rdata_w;
    logic        inst_valid, inst_valid_w;
    logic [31:0] instruction, instruction_w;
    logic [31:0] pc, pc_w;
    logic [31:0] pc_new, pc_new_w;
    logic [2:0]  count, count_w;
    fetch_state_e state_dbg, state_dbg_w;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_word;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign imem_rdata_w = mem_word(imem_addr_w);

    mips_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .pc(pc), .pc_new(pc_new), .count(count),
        .state_dbg(state_dbg)
    );

    mips_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clock(clock), .reset(reset), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata_w), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid_w), .inst_ready(inst_ready),
        .instruction(instruction_w), .pc(pc_w), .pc_new(pc_new_w), .count(count_w),
        .state_dbg(state_dbg_w)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        tick();
        tick();
        check("rst_req",   imem_req,   0);
        check("rst_valid", inst_valid, 0);
        check("rst_count", count,      0);
        check("rst_state", state_dbg,  ST_IDLE);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] a);
        check({tag, "_req"},  imem_req,  1);
        check({tag, "_addr"}, imem_addr, a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    // Scoreboard: every accepted head entry must match the next expected fetch.
    always @(negedge clock) begin
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pop observed pc=%h expected=empty", pc);
            end
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                check("pop_head",   {pc, instruction}, exp_word);
                check("pop_pc_new", pc_new, exp_word[63:32] + 32'd4);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // Streaming from reset, plus wrap-around on the second instance
        do_reset();
        check("t1_idle_req", imem_req, 0);
        inst_ready = 1'b1;
        imem_ack   = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_fetch("t1", 32'(4 * k));
            if (k == 0) begin
                check("t1_valid_early", inst_valid, 0);
                check("t1w_addr", imem_addr_w, 32'hFFFF_FFFC);
            end
            if (k == 1) begin
                check("t1_valid_first", inst_valid, 1);
                check("t1w_pc0",   pc_w,          32'hFFFF_FFFC);
                check("t1w_inst0", instruction_w, mem_word(32'hFFFF_FFFC));
                check("t1w_pcnew", pc_new_w,      32'h0);
            end
            if (k == 2) check("t1w_pc1", pc_w, 32'h0);
            if (k >= 1) check("t1_count", count, 1);
            tick();
        end
        imem_ack = 1'b0;
        repeat (3) tick();
        check("t1_drained", exp_q.size(), 0);

        // Backpressure fills the buffer and stops fetching
        do_reset();
        imem_ack = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_fetch("t2", 32'(4 * k));
            tick();
        end
        check("t2_full",     count,    4);
        check("t2_req_drop", imem_req, 0);
        repeat (2) tick();
        check("t2_no_fifth", count,    4);
        check("t2_still_id", imem_req, 0);
        inst_ready = 1'b1;
        tick();
        check("t2_count3", count, 3);
        expect_fetch("t2_resume", 32'h10);
        tick();
        imem_ack = 1'b0;
        repeat (4) tick();
        check("t2_empty", count, 0);
        check("t2_valid", inst_valid, 0);
        check("t2_drained", exp_q.size(), 0);

        // Redirect while a request waits for its ack
        do_reset();
        inst_ready = 1'b1;
        imem_ack   = 1'b1;
        tick();
        expect_fetch("t3a", 32'h0);
        tick();
        expect_fetch("t3b", 32'h4);
        tick();
        imem_ack = 1'b0;
        check("t3_wait_addr", imem_addr, 32'h8);
        tick();
        check("t3_wait_addr2", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("t3_state_disc", state_dbg, ST_DISCARD);
        check("t3_disc_req",   imem_req,  1);
        check("t3_disc_addr",  imem_addr, 32'h8);
        check("t3_disc_count", count,     0);
        tick();
        check("t3_disc_addr2", imem_addr, 32'h8);
        imem_ack = 1'b1;
        tick();
        check("t3_state_req", state_dbg, ST_REQ);
        check("t3_dropped", inst_valid, 0);
        expect_fetch("t3_target", 32'h100);
        tick();
        imem_ack = 1'b0;
        repeat (2) tick();
        check("t3_drained", exp_q.size(), 0);

        // Redirect, ack and pop together
        do_reset();
        imem_ack = 1'b1;
        tick();
        expect_fetch("t4a", 32'h0);
        tick();
        expect_fetch("t4b", 32'h4);
        tick();
        check("t4_count2", count, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        inst_ready     = 1'b1;
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        check("t4_count0", count, 0);
        check("t4_valid0", inst_valid, 0);
        imem_ack = 1'b1;
        expect_fetch("t4_target", 32'h200);
        tick();
        imem_ack = 1'b0;
        repeat (2) tick();
        check("t4_drained", exp_q.size(), 0);

        // Later redirect replaces an earlier pending target
        do_reset();
        inst_ready = 1'b1;
        tick();
        check("t7_addr0", imem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        tick();
        redirect_pc = 32'h600;
        tick();
        redirect_valid = 1'b0;
        check("t7_state", state_dbg, ST_DISCARD);
        check("t7_hold",  imem_addr, 32'h0);
        imem_ack = 1'b1;
        tick();
        expect_fetch("t7_target", 32'h600);
        tick();
        imem_ack = 1'b0;
        repeat (2) tick();
        check("t7_drained", exp_q.size(), 0);

        // Reset mid-burst overrides redirect, ack and pop
        do_reset();
        imem_ack = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            expect_fetch("t6", 32'(4 * k));
            tick();
        end
        check("t6_count3", count, 3);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        inst_ready     = 1'b1;
        tick();
        check("t6_rst_count", count,      0);
        check("t6_rst_req",   imem_req,   0);
        check("t6_rst_valid", inst_valid, 0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        tick();
        expect_fetch("t6_refetch", 32'h0);
        tick();
        imem_ack = 1'b0;
        repeat (2) tick();
        check("t6_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
